// File: rtl/jtag_pkg.sv
// Shared types for the JTAG data-register bank: TAP states, decoded
// instructions, bank error status and the internal register-select encoding.
package jtag_pkg;

  localparam int DR_BANK_MAX_W = 128;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET,
    RUN_TEST_IDLE,
    SELECT_DR_SCAN,
    CAPTURE_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPDATE_DR,
    SELECT_IR_SCAN,
    CAPTURE_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPDATE_IR
  } tap_ctrl_fsm_t;

  typedef enum logic [1:0] {
    BYPASS,
    IDCODE,
    USER_DR,
    SAMPLE_PRELOAD
  } ir_decoding_t;

  typedef struct packed {
    logic len_err;
    logic ovr_err;
  } s_dr_bank_err_t;

  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_IDCODE,
    SEL_USER
  } dr_sel_t;

endpackage

// File: rtl/jtag_tdo_retime.sv
// Falling-edge retiming of the serial output and its drive enable.
module jtag_tdo_retime (
  input  logic tck,
  input  logic trstn,
  input  logic shift_en,
  input  logic sdo,
  output logic tdo,
  output logic tdo_en
);

  always_ff @(negedge tck or negedge trstn) begin
    if (!trstn) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo_en <= shift_en;
      tdo    <= shift_en & sdo;
    end
  end

endmodule

// File: rtl/jtag_dr_bank.sv
// JTAG data-register bank: BYPASS, IDCODE and user DRs sharing one shift register.
// Optional shift-length checking is enabled by defining JTAG_DR_LEN_CHECK_EN.
module jtag_dr_bank
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE_VAL  = 32'hBADC0FFE,
  parameter int          NUM_USER_DR = 4,
  parameter int          DR_WIDTH    = 40,
  parameter int          IDX_W       = (NUM_USER_DR > 1) ? $clog2(NUM_USER_DR) : 1
) (
  input  logic                            tck,
  input  logic                            trstn,
  input  logic                            tdi,
  output logic                            tdo,
  output logic                            tdo_en,
  input  tap_ctrl_fsm_t                   tap_state,
  input  ir_decoding_t                    ir_dec,
  input  logic [IDX_W-1:0]                user_idx,
  input  logic [NUM_USER_DR*DR_WIDTH-1:0] dr_cap_data,
  input  logic [NUM_USER_DR-1:0]          dr_busy,
  output logic                            dr_upd_valid,
  output logic [IDX_W-1:0]                dr_upd_idx,
  output logic [DR_WIDTH-1:0]             dr_upd_data,
  output logic                            len_err,
  output logic                            ovr_err
);

  localparam int SR_W = (DR_WIDTH > 32) ? DR_WIDTH : 32;
  localparam logic [IDX_W:0] NUM_U = (IDX_W+1)'(NUM_USER_DR);

  logic [SR_W-1:0]     sr;
  logic [SR_W-1:0]     sr_shift;
  logic [SR_W-1:0]     cap_val;
  logic [DR_WIDTH-1:0] cap_sel;
  logic                busy_sel;
  logic                len_ok;
  dr_sel_t             sel;
  s_dr_bank_err_t      err;

  always_comb begin
    cap_sel  = '0;
    busy_sel = 1'b0;
    for (int i = 0; i < NUM_USER_DR; i++) begin
      if (user_idx == IDX_W'(i)) begin
        cap_sel  = dr_cap_data[i*DR_WIDTH +: DR_WIDTH];
        busy_sel = dr_busy[i];
      end
    end
  end

  // Out-of-range user indices and unknown instructions fall back to BYPASS.
  always_comb begin
    sel = SEL_BYPASS;
    if (ir_dec == IDCODE) begin
      sel = SEL_IDCODE;
    end else if (ir_dec == USER_DR && {1'b0, user_idx} < NUM_U) begin
      sel = SEL_USER;
    end
  end

  always_comb begin
    cap_val  = '0;
    sr_shift = sr;
    case (sel)
      SEL_IDCODE: begin
        cap_val[31:0]  = IDCODE_VAL;
        sr_shift[31:0] = {tdi, sr[31:1]};
      end
      SEL_USER: begin
        cap_val[DR_WIDTH-1:0]  = cap_sel;
        sr_shift[DR_WIDTH-1:0] = {tdi, sr[DR_WIDTH-1:1]};
      end
      default: sr_shift[0] = tdi;
    endcase
  end

`ifdef JTAG_DR_LEN_CHECK_EN
  localparam int CNT_W = $clog2(DR_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(DR_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DR_WIDTH + 1);

  logic [CNT_W-1:0] cnt;

  // Saturating at DR_WIDTH+1 keeps over-long shifts distinguishable from exact ones.
  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      cnt <= '0;
    end else begin
      case (tap_state)
        TEST_LOGIC_RESET, CAPTURE_DR: cnt <= '0;
        SHIFT_DR: if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign len_ok = (cnt == CNT_LEN);
`else
  assign len_ok = 1'b1;
`endif

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      sr           <= '0;
      err          <= '0;
      dr_upd_valid <= 1'b0;
      dr_upd_idx   <= '0;
      dr_upd_data  <= '0;
    end else begin
      dr_upd_valid <= 1'b0;
      case (tap_state)
        TEST_LOGIC_RESET: begin
          sr  <= '0;
          err <= '0;
        end
        CAPTURE_DR: sr <= cap_val;
        SHIFT_DR:   sr <= sr_shift;
        UPDATE_DR: begin
          if (sel == SEL_USER) begin
            if (!len_ok) begin
              err.len_err <= 1'b1;
            end else if (busy_sel) begin
              err.ovr_err <= 1'b1;
            end else begin
              dr_upd_valid <= 1'b1;
              dr_upd_idx   <= user_idx;
              dr_upd_data  <= sr[DR_WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign len_err = err.len_err;
  assign ovr_err = err.ovr_err;

  jtag_tdo_retime u_tdo_retime (
    .tck      (tck),
    .trstn    (trstn),
    .shift_en (tap_state == SHIFT_DR),
    .sdo      (sr[0]),
    .tdo      (tdo),
    .tdo_en   (tdo_en)
  );

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Directed self-checking bench for jtag_dr_bank with immediate assertions.
// Covers IDCODE, BYPASS, user DR capture/update, error flags and async reset.
module tb_jtag_dr_bank;
  import jtag_pkg::*;

  localparam int NU = 4;
  localparam int DW = 40;
  localparam int IW = 3;
  localparam logic [31:0] EXP_ID = 32'hBADC0FFE;

  logic                tck;
  logic                trstn;
  logic                tdi;
  logic                tdo;
  logic                tdo_en;
  tap_ctrl_fsm_t       tap_state;
  ir_decoding_t        ir_dec;
  logic [IW-1:0]       user_idx;
  logic [NU*DW-1:0]    dr_cap_data;
  logic [NU-1:0]       dr_busy;
  logic                dr_upd_valid;
  logic [IW-1:0]       dr_upd_idx;
  logic [DW-1:0]       dr_upd_data;
  logic                len_err;
  logic                ovr_err;

  int   checks;
  int   failures;
  logic obs_tdo;
  logic obs_en;

  jtag_dr_bank #(
    .IDCODE_VAL  (32'hBADC0FFE),
    .NUM_USER_DR (NU),
    .DR_WIDTH    (DW),
    .IDX_W       (IW)
  ) dut (
    .tck          (tck),
    .trstn        (trstn),
    .tdi          (tdi),
    .tdo          (tdo),
    .tdo_en       (tdo_en),
    .tap_state    (tap_state),
    .ir_dec       (ir_dec),
    .user_idx     (user_idx),
    .dr_cap_data  (dr_cap_data),
    .dr_busy      (dr_busy),
    .dr_upd_valid (dr_upd_valid),
    .dr_upd_idx   (dr_upd_idx),
    .dr_upd_data  (dr_upd_data),
    .len_err      (len_err),
    .ovr_err      (ovr_err)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  // One TAP cycle: drive state/tdi, capture tdo at mid-cycle, return just after the posedge.
  task automatic applyStimulus(input tap_ctrl_fsm_t st, input logic d);
    tap_state = st;
    tdi       = d;
    @(negedge tck);
    #1;
    obs_tdo = tdo;
    obs_en  = tdo_en;
    @(posedge tck);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
      $error("[TB] check %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] id_v;
    logic [7:0]  byp_v;
    logic [DW-1:0] cap2_v;
    logic [DW-1:0] in2_v;

    checks    = 0;
    failures  = 0;
    obs_tdo   = 1'b0;
    obs_en    = 1'b0;
    trstn     = 1'b0;
    tdi       = 1'b0;
    tap_state = TEST_LOGIC_RESET;
    ir_dec    = BYPASS;
    user_idx  = '0;
    dr_busy   = '0;
    dr_cap_data = {40'hCC_CCCC_CCCC, 40'h12_3456_789A, 40'h00_0000_0000, 40'h5A_5A5A_5A5B};
    id_v   = EXP_ID;
    byp_v  = 8'hA5;
    cap2_v = 40'h12_3456_789A;
    in2_v  = 40'hDE_ADBE_EF01;

    #2;
    checkOutput("rst_tdo", tdo, 0);
    checkOutput("rst_tdo_en", tdo_en, 0);
    checkOutput("rst_valid", dr_upd_valid, 0);
    checkOutput("rst_idx", dr_upd_idx, 0);
    checkOutput("rst_data", dr_upd_data, 0);
    checkOutput("rst_len_err", len_err, 0);
    checkOutput("rst_ovr_err", ovr_err, 0);
    @(posedge tck);
    #1;
    trstn = 1'b1;
    applyStimulus(TEST_LOGIC_RESET, 1'b0);
    applyStimulus(RUN_TEST_IDLE, 1'b0);

    $display("[TB] IDCODE scan");
    ir_dec = IDCODE;
    applyStimulus(CAPTURE_DR, 1'b0);
    checkOutput("id_cap_en", obs_en, 0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(SHIFT_DR, 1'b0);
      checkOutput("id_tdo", obs_tdo, id_v[i]);
      checkOutput("id_tdo_en", obs_en, 1);
    end
    applyStimulus(EXIT1_DR, 1'b0);
    checkOutput("id_exit_en", obs_en, 0);
    checkOutput("id_exit_tdo", obs_tdo, 0);
    applyStimulus(UPDATE_DR, 1'b0);
    checkOutput("id_upd_valid", dr_upd_valid, 0);
    applyStimulus(RUN_TEST_IDLE, 1'b0);

    $display("[TB] BYPASS scan");
    ir_dec = BYPASS;
    applyStimulus(CAPTURE_DR, 1'b0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(SHIFT_DR, (i < 8) ? byp_v[i] : 1'b0);
      checkOutput("byp_tdo", obs_tdo, (i == 0) ? 1'b0 : byp_v[i-1]);
    end
    applyStimulus(EXIT1_DR, 1'b0);
    applyStimulus(UPDATE_DR, 1'b0);
    checkOutput("byp_upd_valid", dr_upd_valid, 0);
    applyStimulus(RUN_TEST_IDLE, 1'b0);

    $display("[TB] USER_DR idx 2 capture and update");
    ir_dec   = USER_DR;
    user_idx = 3'd2;
    applyStimulus(CAPTURE_DR, 1'b0);
    for (int i = 0; i < DW; i++) begin
      applyStimulus(SHIFT_DR, in2_v[i]);
      checkOutput("u2_tdo", obs_tdo, cap2_v[i]);
    end
    applyStimulus(EXIT1_DR, 1'b0);
    checkOutput("u2_pre_valid", dr_upd_valid, 0);
    applyStimulus(UPDATE_DR, 1'b0);
    checkOutput("u2_valid", dr_upd_valid, 1);
    checkOutput("u2_idx", dr_upd_idx, 2);
    checkOutput("u2_data", dr_upd_data, 40'hDE_ADBE_EF01);
    applyStimulus(RUN_TEST_IDLE, 1'b0);
    checkOutput("u2_valid_drop", dr_upd_valid, 0);
    checkOutput("u2_data_hold", dr_upd_data, 40'hDE_ADBE_EF01);
    checkOutput("u2_len_err", len_err, 0);

    $display("[TB] USER_DR idx 1 short shift");
    user_idx = 3'd1;
    applyStimulus(CAPTURE_DR, 1'b0);
    for (int i = 0; i < DW - 1; i++) applyStimulus(SHIFT_DR, 1'b1);
    applyStimulus(EXIT1_DR, 1'b0);
    applyStimulus(UPDATE_DR, 1'b0);
`ifdef JTAG_DR_LEN_CHECK_EN
    checkOutput("u1_valid", dr_upd_valid, 0);
    checkOutput("u1_len_err", len_err, 1);
`else
    checkOutput("u1_valid", dr_upd_valid, 1);
    checkOutput("u1_idx", dr_upd_idx, 1);
    checkOutput("u1_data", dr_upd_data, 40'hFF_FFFF_FFFE);
    checkOutput("u1_len_err", len_err, 0);
`endif
    applyStimulus(TEST_LOGIC_RESET, 1'b0);
    checkOutput("tlr_len_err", len_err, 0);
    applyStimulus(RUN_TEST_IDLE, 1'b0);

    $display("[TB] USER_DR idx 3 busy consumer");
    user_idx = 3'd3;
    dr_busy  = 4'b1000;
    applyStimulus(CAPTURE_DR, 1'b0);
    for (int i = 0; i < DW; i++) applyStimulus(SHIFT_DR, 1'b0);
    applyStimulus(EXIT1_DR, 1'b0);
    applyStimulus(UPDATE_DR, 1'b0);
    checkOutput("u3_valid", dr_upd_valid, 0);
    checkOutput("u3_ovr_err", ovr_err, 1);
    checkOutput("u3_len_err", len_err, 0);
    applyStimulus(RUN_TEST_IDLE, 1'b0);
    checkOutput("u3_ovr_sticky", ovr_err, 1);
    dr_busy = '0;
    applyStimulus(TEST_LOGIC_RESET, 1'b0);
    checkOutput("tlr_ovr_err", ovr_err, 0);
    applyStimulus(RUN_TEST_IDLE, 1'b0);

    $display("[TB] out-of-range index behaves as bypass");
    user_idx = 3'd5;
    applyStimulus(CAPTURE_DR, 1'b0);
    applyStimulus(SHIFT_DR, 1'b1);
    checkOutput("oor_tdo0", obs_tdo, 0);
    applyStimulus(SHIFT_DR, 1'b0);
    checkOutput("oor_tdo1", obs_tdo, 1);
    applyStimulus(SHIFT_DR, 1'b1);
    checkOutput("oor_tdo2", obs_tdo, 0);
    applyStimulus(SHIFT_DR, 1'b0);
    checkOutput("oor_tdo3", obs_tdo, 1);
    applyStimulus(EXIT1_DR, 1'b0);
    applyStimulus(UPDATE_DR, 1'b0);
    checkOutput("oor_valid", dr_upd_valid, 0);
    checkOutput("oor_len_err", len_err, 0);
    checkOutput("oor_ovr_err", ovr_err, 0);
    applyStimulus(RUN_TEST_IDLE, 1'b0);

    $display("[TB] async reset mid-shift");
    user_idx = 3'd0;
    applyStimulus(CAPTURE_DR, 1'b0);
    applyStimulus(SHIFT_DR, 1'b0);
    checkOutput("mid_tdo_before", obs_tdo, 1);
    checkOutput("mid_en_before", obs_en, 1);
    trstn = 1'b0;
    #1;
    checkOutput("mid_rst_tdo", tdo, 0);
    checkOutput("mid_rst_tdo_en", tdo_en, 0);
    checkOutput("mid_rst_valid", dr_upd_valid, 0);
    checkOutput("mid_rst_idx", dr_upd_idx, 0);
    checkOutput("mid_rst_data", dr_upd_data, 0);
    checkOutput("mid_rst_len", len_err, 0);
    checkOutput("mid_rst_ovr", ovr_err, 0);
    @(posedge tck);
    #1;
    trstn = 1'b1;
    applyStimulus(TEST_LOGIC_RESET, 1'b0);
    checkOutput("post_rst_data", dr_upd_data, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
